uart_tx: RTL and testbench

- Serial transmit end of the UART byte port that the memory-access stage drives through `uart`/`uart_we`.
- Buffers bytes in a small FIFO so store bursts do not stall the pipeline.
- Serialises each byte as 8N1 on `txd` at a fixed baud derived from `clk`.
- Sits at top level between the core's UART byte port and the board TX pin.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_if.sv | 21 ++
 rtl/byte_fifo.sv | 66 ++++++
 rtl/uart_tx.sv | 134 +++++++++++++
 tb/tb_uart_tx.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART blocks
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - core-side byte port and status of the UART transmitter
interface uart_tx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] uart;
    logic                      uart_we;
    logic                      txd;
    logic                      fifo_full;
    logic                      tx_busy;
    logic                      overflow;

    modport master (
        output uart, uart_we,
        input  txd, fifo_full, tx_busy, overflow
    );

    modport slave (
        input  uart, uart_we,
        output txd, fifo_full, tx_busy, overflow
    );
endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two FIFO with registered full/empty flags
module byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rstd,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != (AW+1)'(DEPTH)) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 serial transmitter
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic     clk,
    input  logic     rstd,
    uart_tx_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    uart_state_e               state_q, state_d;
    logic [CW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                      txd_q, txd_d;
    logic                      busy_q, busy_d;
    logic                      ovf_q, ovf_d;

    logic                      pop, push_ok, baud_tick;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic                      fifo_full, fifo_empty;
    logic [AW:0]               fifo_count;

    byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(UART_DATA_BITS)) u_fifo (
        .clk   (clk),
        .rstd  (rstd),
        .push  (push_ok),
        .din   (bus.uart),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign baud_tick = (baud_q == CW'(CLKS_PER_BIT - 1));

    // txd_d is the level of the bit that starts on this edge, so the line is a pure flop.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    sh_d    = fifo_dout;
                    baud_d  = '0;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    txd_d   = sh_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    sh_d   = {1'b0, sh_q[UART_DATA_BITS-1:1]};
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        txd_d = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        sh_d    = fifo_dout;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        push_ok = bus.uart_we && ((fifo_count != (AW+1)'(FIFO_DEPTH)) || pop);
        ovf_d   = ovf_q || (bus.uart_we && !push_ok);
        busy_d  = (state_q != IDLE) || (fifo_count != '0);
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.txd       = txd_q;
    assign bus.fifo_full = fifo_full;
    assign bus.tx_busy   = busy_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized scoreboard bench for uart_tx
module tb_uart_tx;
    localparam int C = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rstd;
    uart_tx_if bus();

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk  (clk),
        .rstd (rstd),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: byte queue plus the number of cycles left in the frame on the wire.
    int         m_left;
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_cur;
    bit         m_ovf, m_busy, m_full, m_txd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_q.delete();
        exp_q.delete();
        m_ovf  = 0;
        m_busy = 0;
        m_full = 0;
        m_txd  = 1;
    endtask

    task automatic model_step(input bit we, input logic [7:0] d);
        bit         busy_pre, popped;
        logic [9:0] fr;
        busy_pre = (m_left != 0) || (m_q.size() != 0);
        popped   = (m_q.size() != 0) && (m_left <= 1);
        if (m_left != 0) m_left--;
        if (popped) begin
            m_cur  = m_q.pop_front();
            m_left = 10 * C;
        end
        if (we) begin
            if (m_q.size() < D) begin
                m_q.push_back(d);
                exp_q.push_back(d);
            end else begin
                m_ovf = 1;
            end
        end
        m_busy = busy_pre;
        m_full = (m_q.size() == D);
        if (m_left != 0) begin
            fr    = {1'b1, m_cur, 1'b0};
            m_txd = fr[(10 * C - m_left) / C];
        end else begin
            m_txd = 1;
        end
    endtask

    task automatic cycle(input bit we, input logic [7:0] d);
        @(negedge clk);
        bus.uart_we = we;
        bus.uart    = d;
        @(posedge clk);
        model_step(we, d);
        #1;
        check("flags{txd,full,busy,ovf}",
              {28'd0, bus.txd, bus.fifo_full, bus.tx_busy, bus.overflow},
              {28'd0, m_txd, m_full, m_busy, m_ovf});
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2;
        rstd        = 1'b0;
        bus.uart_we = 1'b0;
        #1;
        check("rst_txd", bus.txd, 1);
        check("rst_busy", bus.tx_busy, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_full", bus.fifo_full, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstd = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 600; i++) begin
            if (m_left == 0 && m_q.size() == 0) break;
            cycle(0, 8'h00);
        end
        repeat (2) cycle(0, 8'h00);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Serial monitor: decodes frames mid-bit and pops the scoreboard.
    bit         in_frame = 0;
    int         mcnt;
    logic [9:0] mon_frame;

    always @(negedge clk) begin
        if (rstd !== 1'b1) begin
            in_frame = 0;
        end else begin
            if (!in_frame && bus.txd === 1'b0) begin
                in_frame = 1;
                mcnt     = 0;
            end
            if (in_frame) begin
                if (mcnt % C == C / 2) begin
                    mon_frame[mcnt / C] = bus.txd;
                    if (mcnt / C == 9) begin
                        in_frame = 0;
                        check("start_bit", mon_frame[0], 0);
                        check("stop_bit", mon_frame[9], 1);
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL rx_byte: got unexpected frame %0h expected none", mon_frame[8:1]);
                        end else begin
                            check("rx_byte", mon_frame[8:1], exp_q.pop_front());
                        end
                    end
                end
                mcnt++;
            end
        end
    end

    initial begin
        bit found;
        rstd        = 1'b0;
        bus.uart_we = 1'b0;
        bus.uart    = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("por_txd", bus.txd, 1);
        check("por_busy", bus.tx_busy, 0);
        check("por_full", bus.fifo_full, 0);
        check("por_ovf", bus.overflow, 0);
        @(negedge clk);
        rstd = 1'b1;

        repeat (50) cycle(0, 8'h00);

        cycle(1, 8'hA5);
        drain();

        cycle(1, 8'h01);
        cycle(1, 8'h02);
        cycle(1, 8'h03);
        drain();

        for (int i = 0; i < 6; i++) cycle(1, 8'h10 + 8'(i));
        drain();
        check("t4_ovf_sticky", bus.overflow, 1);

        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1, 8'h20 + 8'(i));
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_left == 1 && m_q.size() == D) begin
                found = 1;
                break;
            end
            cycle(0, 8'h00);
        end
        check("t5_reached_full_stop", found, 1);
        cycle(1, 8'h5A);
        check("t5_full_kept", bus.fifo_full, 1);
        check("t5_no_ovf", bus.overflow, 0);
        drain();

        cycle(1, 8'h00);
        repeat (12) cycle(0, 8'h00);
        apply_reset();
        cycle(1, 8'h55);
        drain();

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) < 20, 8'($urandom));
        end
        drain();
        check("final_no_frame", in_frame, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
